note_timer: RTL and testbench
=============================

NOTE_TIMER -- requirements
Module: note_timer

Interface
REQ-001 SHALL have parameter GAP_CYC, default 3, meaning the number of idle cycles forced after each note so the upstream melody FSM sees Duracao low and presents its next Temp/Freq.
REQ-002 SHALL have parameter W, default 28, meaning the width of the duration and period counts.
REQ-003 SHALL have port Clk_in, input, 1, the single system clock (16 MHz); there is one clock and reset is synchronous and active-high.
REQ-004 SHALL have port Rst_in, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Stop_in, input, 1, level abort of the current note.
REQ-006 SHALL have port Disparo, input, 1, level request to start a note.
REQ-007 SHALL have port Temp_in, input, W, note duration in Clk_in cycles.
REQ-008 SHALL have port Freq_in, input, W, tone full period in Clk_in cycles; 0 means rest.
REQ-009 SHALL have port Duracao, output, 1, registered busy flag, high only while a note plays.
REQ-010 SHALL have port Buzzer_out, output, 1, registered square-wave tone.
REQ-011 SHALL have port Fim, output, 1, registered one-cycle pulse on normal note completion.

Function
REQ-012 SHALL implement the states IDLE, PLAY and GAP; Duracao is 1 only in PLAY.
REQ-013 IDLE: with Disparo=1 and Stop_in=0, SHALL latch Temp_in as T and Freq_in as F, clear both counters and enter PLAY on the next cycle; otherwise it stays in IDLE.
REQ-014 T and F SHALL be held constant during PLAY; changes on Temp_in and Freq_in during PLAY or GAP are ignored.
REQ-015 PLAY: the duration counter SHALL increment every cycle from 0; at count == max(T,1)-1 the next state is GAP, so Duracao is high for exactly max(T,1) cycles (T=0 behaves as T=1).
REQ-016 Fim SHALL be 1 for exactly the first GAP cycle after a normal PLAY expiry, and 0 at all other times.
REQ-017 GAP SHALL last exactly GAP_CYC cycles, then enter IDLE; Disparo is ignored in GAP.
REQ-018 With Disparo held high, Duracao SHALL be low for GAP_CYC+1 cycles between consecutive notes.
REQ-019 The period counter SHALL run 0..F-1 and wrap to 0 during PLAY; in PLAY cycle k (k=0 first), Buzzer_out=1 iff F>=2 and (k mod F) < floor(F/2).
REQ-020 Buzzer_out SHALL be 0 outside PLAY; F=0 and F=1 give a silent note with normal duration and Fim.
REQ-021 Stop_in=1 SHALL force IDLE on the next cycle from any state, with Duracao=0, Buzzer_out=0 and no Fim pulse; a note never starts while Stop_in=1.
REQ-022 Stop_in and expiry in the same cycle SHALL resolve to Stop (IDLE, no Fim).
REQ-023 Counters SHALL be W bits unsigned with compares only, so no overflow is possible for T and F < 2^W.

Reset
REQ-024 Rst_in=1 SHALL, on the next Clk_in edge, force IDLE and set Duracao=0, Buzzer_out=0, Fim=0 and counters, T and F to 0.
REQ-025 Rst_in SHALL take priority over Stop_in and Disparo.
REQ-026 Reset mid-PLAY SHALL abort with no Fim pulse.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE, PLAY, GAP), W=28, CLK_HZ=16000000 and the note-period and beat-count constants also used by the melody FSMs.
REQ-028 The period counter and square-wave compare SHALL be one sub-module, tone_divider (inputs: enable, F; output: wave), reusable by other song blocks.

Verification
REQ-029 T=10, F=4, single Disparo pulse -> Duracao high 10 cycles; Buzzer_out 1,1,0,0,1,1,0,0,1,1; Fim pulse in the 11th cycle; IDLE after 3 more cycles.
REQ-030 T=6, F=5 -> Buzzer_out 1,1,0,0,0,1; F=0 or F=1 -> Buzzer_out constant 0 with Duracao high 6 cycles and Fim pulsed.
REQ-031 Disparo held high, T=4 -> Duracao pattern 4 high, 4 low, repeating; new Temp_in/Freq_in applied 2 cycles after Duracao falls is used by the next note.
REQ-032 T=100, Stop_in high at PLAY cycle 5 -> Duracao=0 and Buzzer_out=0 the next cycle, no Fim, no restart while Stop_in=1.
REQ-033 Rst_in at PLAY cycle 3, and Stop_in coincident with the last PLAY cycle -> IDLE, all outputs 0, no Fim.
REQ-034 T=0 -> Duracao high 1 cycle, then Fim.

Source files
------------

// File: rtl/note_timer_pkg.sv
// Shared constants and state encoding for the note timer and melody FSMs.
// Holds counter width, clock rate, note periods and beat lengths.
package note_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } nt_state_t;

  localparam int NOTE_W = 28;
  localparam int CLK_HZ = 16000000;

  // Full tone period in clock cycles for a given pitch in Hz.
  function automatic int period_of(input int hz);
    return CLK_HZ / hz;
  endfunction

  localparam int P_REST = 0;
  localparam int P_C4   = CLK_HZ / 262;
  localparam int P_D4   = CLK_HZ / 294;
  localparam int P_E4   = CLK_HZ / 330;
  localparam int P_F4   = CLK_HZ / 349;
  localparam int P_G4   = CLK_HZ / 392;
  localparam int P_A4   = CLK_HZ / 440;
  localparam int P_B4   = CLK_HZ / 494;
  localparam int P_C5   = CLK_HZ / 523;

  // Beat lengths at 120 bpm (quarter note = 0.5 s).
  localparam int BEAT_W = CLK_HZ * 2;
  localparam int BEAT_H = CLK_HZ;
  localparam int BEAT_Q = CLK_HZ / 2;
  localparam int BEAT_E = CLK_HZ / 4;

endpackage

// File: rtl/note_timer_tone_divider.sv
// tone_divider: square wave of period F cycles while enable is high.
// Ports: Clk_in, Rst_in, enable, F (period), wave (registered output).
module tone_divider
  import note_timer_pkg::*;
#(
  parameter int W = NOTE_W
) (
  input  logic         Clk_in,
  input  logic         Rst_in,
  input  logic         enable,
  input  logic [W-1:0] F,
  output logic         wave
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  logic [W-1:0] ph;
  logic [W-1:0] half;
  logic [W-1:0] last;

  assign half = F >> 1;
  assign last = F - ONE;

  // enable describes the cycle being produced,
  // so ph is the phase of that upcoming cycle.
  always_ff @(posedge Clk_in) begin
    if (Rst_in || !enable) begin
      ph   <= '0;
      wave <= 1'b0;
    end else begin
      wave <= (F >= TWO) && (ph < half);
      if (F < TWO || ph == last)
        ph <= '0;
      else
        ph <= ph + ONE;
    end
  end

endmodule

// File: rtl/note_timer.sv
// note_timer: plays one note (duration T, tone period F) then a fixed gap.
// Ports: Clk_in, Rst_in, Stop_in, Disparo, Temp_in, Freq_in -> Duracao, Buzzer_out, Fim.
module note_timer
  import note_timer_pkg::*;
#(
  parameter int GAP_CYC = 3,
  parameter int W       = NOTE_W
) (
  input  logic         Clk_in,
  input  logic         Rst_in,
  input  logic         Stop_in,
  input  logic         Disparo,
  input  logic [W-1:0] Temp_in,
  input  logic [W-1:0] Freq_in,
  output logic         Duracao,
  output logic         Buzzer_out,
  output logic         Fim
);

  localparam int           GAP_N    = (GAP_CYC > 0) ? GAP_CYC : 1;
  localparam logic [W-1:0] GAP_LAST = W'(GAP_N - 1);
  localparam logic [W-1:0] ONE      = W'(1);

  nt_state_t    state;
  nt_state_t    nxt;
  logic [W-1:0] cnt;
  logic [W-1:0] t_q;
  logic [W-1:0] f_q;
  logic [W-1:0] f_sel;
  logic [W-1:0] play_last;
  logic         start;

  assign start     = (state == ST_IDLE) && Disparo && !Stop_in;
  assign play_last = (t_q == '0) ? '0 : t_q - ONE;
  // On the start edge the divider must already see the new period.
  assign f_sel     = start ? Freq_in : f_q;

  always_comb begin
    nxt = state;
    if (Stop_in) begin
      nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (Disparo) nxt = ST_PLAY;
        ST_PLAY: if (cnt == play_last) nxt = ST_GAP;
        ST_GAP:  if (cnt == GAP_LAST) nxt = ST_IDLE;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      t_q     <= '0;
      f_q     <= '0;
      Duracao <= 1'b0;
      Fim     <= 1'b0;
    end else begin
      state   <= nxt;
      Duracao <= (nxt == ST_PLAY);
      Fim     <= (state == ST_PLAY) && (nxt == ST_GAP);
      // One counter serves both PLAY duration and GAP length.
      if (state == ST_IDLE || nxt != state)
        cnt <= '0;
      else
        cnt <= cnt + ONE;
      if (start) begin
        t_q <= Temp_in;
        f_q <= Freq_in;
      end
    end
  end

  tone_divider #(
    .W(W)
  ) u_tone (
    .Clk_in (Clk_in),
    .Rst_in (Rst_in),
    .enable (nxt == ST_PLAY),
    .F      (f_sel),
    .wave   (Buzzer_out)
  );

endmodule

// File: tb/tb_note_timer.sv
// Randomized scoreboard bench for note_timer.
// A timeline reference model predicts each cycle's outputs.
module tb_note_timer;

  localparam int W   = 28;
  localparam int GAP = 3;

  logic         Clk_in = 1'b0;
  logic         Rst_in;
  logic         Stop_in;
  logic         Disparo;
  logic [W-1:0] Temp_in;
  logic [W-1:0] Freq_in;
  logic         Duracao;
  logic         Buzzer_out;
  logic         Fim;

  note_timer #(
    .GAP_CYC(GAP),
    .W(W)
  ) dut (
    .Clk_in     (Clk_in),
    .Rst_in     (Rst_in),
    .Stop_in    (Stop_in),
    .Disparo    (Disparo),
    .Temp_in    (Temp_in),
    .Freq_in    (Freq_in),
    .Duracao    (Duracao),
    .Buzzer_out (Buzzer_out),
    .Fim        (Fim)
  );

  always #5 Clk_in = ~Clk_in;

  typedef struct packed {
    logic d;
    logic b;
    logic f;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Model: a note is a time window. Started at cycle s it plays
  // for tm cycles, pulses Fim at s+tm, is busy until s+tm+GAP.
  longint cyc = 0;
  longint s   = 0;
  longint tm  = 0;
  longint fm  = 0;
  bit     act = 0;

  always @(posedge Clk_in) begin : model
    exp_t   e;
    longint k;
    cyc++;
    e = '0;
    if (Rst_in || Stop_in) begin
      act = 0;
    end else begin
      if (act && (cyc - 1 >= s + tm + GAP)) act = 0;
      if (!act && Disparo) begin
        act = 1;
        s   = cyc;
        tm  = (Temp_in == 0) ? 1 : longint'(Temp_in);
        fm  = longint'(Freq_in);
      end
      if (act) begin
        k = cyc - s;
        if (k < tm) begin
          e.d = 1'b1;
          if (fm >= 2) e.b = ((k % fm) < (fm / 2));
        end else if (k == tm) begin
          e.f = 1'b1;
        end
      end
    end
    q.push_back(e);
  end

  always @(negedge Clk_in) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if ({Duracao, Buzzer_out, Fim} !== e) begin
        fails++;
        $display("FAIL cyc%0d D/B/F got %b%b%b exp %b%b%b",
                 cyc, Duracao, Buzzer_out, Fim, e.d, e.b, e.f);
      end
    end
  end

  task automatic note(input int t, input int f);
    @(negedge Clk_in);
    Temp_in = W'(t);
    Freq_in = W'(f);
    Disparo = 1'b1;
    @(negedge Clk_in);
    Disparo = 1'b0;
  endtask

  task automatic idle(input int n);
    Disparo = 1'b0;
    Stop_in = 1'b0;
    Rst_in  = 1'b0;
    repeat (n) @(negedge Clk_in);
  endtask

  task automatic wait_dur(input int lim);
    int n;
    n = 0;
    while (Duracao !== 1'b1 && n < lim) begin
      @(negedge Clk_in);
      n++;
    end
    if (Duracao !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_dur timeout got %b exp 1", Duracao);
    end
  endtask

  initial begin
    bit pd;
    int fall;
    Rst_in  = 1'b1;
    Stop_in = 1'b0;
    Disparo = 1'b0;
    Temp_in = '0;
    Freq_in = '0;
    repeat (3) @(negedge Clk_in);
    idle(2);

    // Basic notes, silent notes and T=0.
    note(10, 4); idle(18);
    note(6, 5);  idle(12);
    note(6, 0);  idle(12);
    note(6, 1);  idle(12);
    note(0, 3);  idle(8);

    // Back-to-back notes with inputs changed mid-gap.
    Temp_in = W'(4);
    Freq_in = W'(3);
    Disparo = 1'b1;
    pd   = 1'b0;
    fall = -10;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk_in);
      if (pd && !Duracao) fall = i;
      if (i == fall + 2) begin
        Temp_in = W'($urandom_range(1, 6));
        Freq_in = W'($urandom_range(0, 6));
      end
      pd = Duracao;
    end
    idle(10);

    // Stop at PLAY cycle 5 with Disparo held.
    note(100, 6);
    wait_dur(4);
    repeat (5) @(negedge Clk_in);
    Stop_in = 1'b1;
    Disparo = 1'b1;
    repeat (6) @(negedge Clk_in);
    idle(3);

    // Reset at PLAY cycle 3.
    note(20, 4);
    repeat (3) @(negedge Clk_in);
    Rst_in = 1'b1;
    @(negedge Clk_in);
    idle(6);

    // Stop coincident with the last PLAY cycle.
    note(5, 2);
    repeat (4) @(negedge Clk_in);
    Stop_in = 1'b1;
    @(negedge Clk_in);
    idle(8);

    // Random traffic, inputs changing every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk_in);
      Rst_in  = ($urandom_range(0, 199) == 0);
      Stop_in = ($urandom_range(0, 49) == 0);
      Disparo = ($urandom_range(0, 3) != 0);
      Temp_in = W'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)
        Freq_in = W'($urandom_range(10, 40));
      else
        Freq_in = W'($urandom_range(0, 9));
    end
    idle(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
